// File: rtl/arm_muldiv_if.sv
// Operand/result bundle between the core controller (master) and the muldiv unit (slave).
interface arm_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result_lo, result_hi, flags, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_lo, result_hi, flags, div_by_zero
    );
endinterface

// File: rtl/arm_muldiv.sv
// Iterative shift-add multiply / restoring divide, one bit per cycle; ARM_MULDIV_SIGNED_EN adds signed ops.
// Latency: WIDTH+1 cycles start->done unsigned, WIDTH+3 signed, 1 for divide by zero.
// Backpressure: none; starts are taken only in IDLE/DONE and dropped while busy is high.
module arm_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    arm_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
`ifdef ARM_MULDIV_SIGNED_EN
        PREP = 3'd1,
`endif
        RUN  = 3'd2,
`ifdef ARM_MULDIV_SIGNED_EN
        FIX  = 3'd3,
`endif
        DONE = 3'd4
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               op_full;
    logic               op_div;
    logic               ovf;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
`ifdef ARM_MULDIV_SIGNED_EN
    logic               sgn;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
`endif

    logic               acc_ok;
    logic               is_div_in;
    logic               div0_in;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] p_step;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [2*WIDTH-1:0] fin_p;
    logic [WIDTH-1:0]   fin_q;
    logic [WIDTH-1:0]   fin_r;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   res_hi;
    logic               res_n;
    logic               res_z;

    // Partial remainder never exceeds the divisor, so its top bit is only needed mid-step.
    logic unused_bits;
`ifdef ARM_MULDIV_SIGNED_EN
    assign unused_bits = rem[WIDTH];
`else
    assign unused_bits = ^{rem[WIDTH], bus.op[2]};
`endif

    assign acc_ok    = bus.start && (state == IDLE || state == DONE);
    assign is_div_in = (bus.op[1:0] == 2'b10);
    assign div0_in   = is_div_in && (bus.b == '0);

    always_comb begin
        mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opb} : '0);
        p_step   = {mul_sum, p[WIDTH-1:1]};
        div_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, opb});
        rem_step = div_ge ? (div_sh - {1'b0, opb}) : div_sh;
        quo_step = {quo[WIDTH-2:0], div_ge};

        // Final values: the last RUN step for unsigned ops, sign-corrected registers in FIX.
        fin_p = p_step;
        fin_q = quo_step;
        fin_r = rem_step[WIDTH-1:0];
`ifdef ARM_MULDIV_SIGNED_EN
        abs_a = quo[WIDTH-1] ? -quo : quo;
        abs_b = opb[WIDTH-1] ? -opb : opb;
        if (state == FIX) begin
            fin_p = neg_q ? -p : p;
            fin_q = neg_q ? -quo : quo;
            fin_r = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        end
`endif

        res_lo = op_div ? fin_q : fin_p[WIDTH-1:0];
        res_hi = op_div ? fin_r : (op_full ? fin_p[2*WIDTH-1:WIDTH] : '0);
        res_n  = op_full ? res_hi[WIDTH-1] : res_lo[WIDTH-1];
        res_z  = op_full ? (res_lo == '0 && res_hi == '0) : (res_lo == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            op_full         <= 1'b0;
            op_div          <= 1'b0;
            ovf             <= 1'b0;
            opb             <= '0;
            p               <= '0;
            rem             <= '0;
            quo             <= '0;
`ifdef ARM_MULDIV_SIGNED_EN
            sgn             <= 1'b0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
`endif
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result_lo   <= '0;
            bus.result_hi   <= '0;
            bus.flags       <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
`ifdef ARM_MULDIV_SIGNED_EN
                PREP: begin
                    neg_q <= quo[WIDTH-1] ^ opb[WIDTH-1];
                    neg_r <= quo[WIDTH-1];
                    p     <= {{WIDTH{1'b0}}, abs_a};
                    quo   <= abs_a;
                    opb   <= abs_b;
                    state <= RUN;
                end
`endif
                RUN: begin
                    p   <= p_step;
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
`ifdef ARM_MULDIV_SIGNED_EN
                        if (sgn) begin
                            state <= FIX;
                        end else
`endif
                        begin
                            state           <= DONE;
                            bus.busy        <= 1'b0;
                            bus.done        <= 1'b1;
                            bus.result_lo   <= res_lo;
                            bus.result_hi   <= res_hi;
                            bus.flags       <= {res_n, res_z, 1'b0, ovf};
                            bus.div_by_zero <= 1'b0;
                        end
                    end
                end
`ifdef ARM_MULDIV_SIGNED_EN
                FIX: begin
                    state           <= DONE;
                    bus.busy        <= 1'b0;
                    bus.done        <= 1'b1;
                    bus.result_lo   <= res_lo;
                    bus.result_hi   <= res_hi;
                    bus.flags       <= {res_n, res_z, 1'b0, ovf};
                    bus.div_by_zero <= 1'b0;
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A new start in IDLE or DONE overrides the default next state above.
            if (acc_ok) begin
                op_full <= (bus.op[1:0] == 2'b01);
                op_div  <= is_div_in;
                opb     <= bus.b;
                p       <= {{WIDTH{1'b0}}, bus.a};
                quo     <= bus.a;
                rem     <= '0;
                cnt     <= '0;
                ovf     <= 1'b0;
                if (div0_in) begin
                    state           <= DONE;
                    bus.busy        <= 1'b0;
                    bus.done        <= 1'b1;
                    bus.result_lo   <= '1;
                    bus.result_hi   <= bus.a;
                    bus.flags       <= 4'b1000;
                    bus.div_by_zero <= 1'b1;
                end else begin
                    bus.busy <= 1'b1;
`ifdef ARM_MULDIV_SIGNED_EN
                    sgn   <= bus.op[2];
                    state <= bus.op[2] ? PREP : RUN;
                    ovf   <= bus.op[2] && is_div_in &&
                             (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
`else
                    state <= RUN;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_arm_muldiv.sv
// Self-checking bench for arm_muldiv: directed cases plus random ops against an arithmetic model.
module tb_arm_muldiv;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef ARM_MULDIV_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    arm_muldiv_if #(.WIDTH(32)) i32 ();
    arm_muldiv_if #(.WIDTH(8))  i8  ();

    arm_muldiv #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(i32));
    arm_muldiv #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(i8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic void model(input int w, input logic [2:0] op,
                                  input logic [63:0] a_in, input logic [63:0] b_in,
                                  output logic [63:0] lo, output logic [63:0] hi,
                                  output logic [3:0] fl, output logic dz, output int lat);
        logic [63:0] m, m2, ua, ub, prod;
        longint sa, sb, q, r;
        logic sg, full, v;
        m    = (64'd1 << w) - 64'd1;
        m2   = (w == 32) ? ~64'd0 : ((64'd1 << (2 * w)) - 64'd1);
        ua   = a_in & m;
        ub   = b_in & m;
        sa   = ua[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
        sb   = ub[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
        sg   = op[2] && SGN_EN;
        full = (op[1:0] == 2'b01);
        v    = 1'b0;
        dz   = 1'b0;
        hi   = 64'd0;
        if (op[1:0] == 2'b10) begin
            if (ub == 64'd0) begin
                lo = m;
                hi = ua;
                dz = 1'b1;
            end else if (sg) begin
                q  = sa / sb;
                r  = sa % sb;
                lo = 64'(q) & m;
                hi = 64'(r) & m;
                v  = (sa == -(longint'(1) << (w - 1))) && (sb == -1);
            end else begin
                lo = ua / ub;
                hi = ua % ub;
            end
        end else begin
            prod = sg ? (64'(sa * sb) & m2) : ((ua * ub) & m2);
            lo   = prod & m;
            if (full) hi = (prod >> w) & m;
        end
        fl  = {full ? hi[w-1] : lo[w-1], full ? (lo == 0 && hi == 0) : (lo == 0), 1'b0, v};
        lat = dz ? 1 : (sg ? w + 3 : w + 1);
    endfunction

    task automatic do_op32(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b, input int pulse_at);
        logic [63:0] elo, ehi;
        logic [3:0]  efl;
        logic        edz;
        int          lat, done_cyc, busy_cnt, both;
        logic [31:0] slo, shi;
        logic [3:0]  sfl;
        logic        sdz;
        model(32, op, {32'd0, a}, {32'd0, b}, elo, ehi, efl, edz, lat);
        slo = 'x; shi = 'x; sfl = 'x; sdz = 1'bx;
        @(negedge clk);
        i32.start = 1'b1; i32.op = op; i32.a = a; i32.b = b;
        @(posedge clk);
        #1;
        i32.start = 1'b0; i32.a = $urandom; i32.b = $urandom; i32.op = 3'($urandom);
        done_cyc = 0; busy_cnt = 0; both = 0;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            i32.start = (c == pulse_at);
            if (i32.busy) busy_cnt++;
            if (i32.busy && i32.done) both++;
            if (i32.done && done_cyc == 0) begin
                done_cyc = c;
                slo = i32.result_lo; shi = i32.result_hi; sfl = i32.flags; sdz = i32.div_by_zero;
            end
        end
        i32.start = 1'b0;
        check({tag, " done_cycle"}, done_cyc, lat);
        check({tag, " busy_cycles"}, busy_cnt + 1000 * both, edz ? 0 : lat - 1);
        check({tag, " result_lo"}, slo, elo[31:0]);
        check({tag, " result_hi"}, shi, ehi[31:0]);
        check({tag, " flags/dz"}, {sfl, sdz}, {efl, edz});
        check({tag, " held"}, {i32.done, i32.result_lo, i32.result_hi, i32.flags, i32.div_by_zero},
              {1'b0, elo[31:0], ehi[31:0], efl, edz});
    endtask

    initial begin
        int d8;
        logic [31:0] ra, rb;
        reset = 1'b1;
        i32.start = 1'b0; i32.op = 3'd0; i32.a = '0; i32.b = '0;
        i8.start  = 1'b0; i8.op  = 3'd0; i8.a  = '0; i8.b  = '0;
        repeat (2) @(negedge clk);
        check("reset32", {i32.busy, i32.done, i32.result_lo, i32.result_hi, i32.flags, i32.div_by_zero}, '0);
        check("reset8", {i8.busy, i8.done, i8.result_lo, i8.result_hi, i8.flags, i8.div_by_zero}, '0);
        reset = 1'b0;

        do_op32("mul_7x6",    3'b000, 32'd7, 32'd6, 0);
        do_op32("mull_ffff",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op32("div_100_7",  3'b010, 32'd100, 32'd7, 0);
        do_op32("div_5_0",    3'b010, 32'd5, 32'd0, 0);
        do_op32("mul_pulse5", 3'b000, 32'd1234, 32'd5678, 5);
        do_op32("rsv_as_mul", 3'b011, 32'h0001_0003, 32'h0000_0100, 0);
        do_op32("mull_zero",  3'b001, 32'd0, 32'hDEAD_BEEF, 0);

        // Reset partway through a DIV drops it and clears every output.
        @(negedge clk);
        i32.start = 1'b1; i32.op = 3'b010; i32.a = 32'd1000; i32.b = 32'd3;
        @(posedge clk);
        #1;
        i32.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset", {i32.busy, i32.done, i32.result_lo, i32.result_hi, i32.flags, i32.div_by_zero}, '0);
        reset = 1'b0;
        do_op32("after_reset", 3'b010, 32'd1000, 32'd3, 0);

`ifdef ARM_MULDIV_SIGNED_EN
        do_op32("sdiv_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 0);
        do_op32("sdiv_min_m1", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op32("smull_m3_5",  3'b101, 32'hFFFF_FFFD, 32'd5, 0);
        do_op32("sdiv_m9_0",   3'b110, 32'hFFFF_FFF7, 32'd0, 0);
`endif

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            do_op32($sformatf("rand%0d", i), 3'($urandom), ra, rb, 0);
        end

        // WIDTH=8: 15x17, with start held through DONE so a second op chains directly.
        @(negedge clk);
        i8.start = 1'b1; i8.op = 3'b000; i8.a = 8'd15; i8.b = 8'd17;
        @(posedge clk);
        #1;
        i8.a = 8'd3; i8.b = 8'd5;
        d8 = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (i8.done && d8 == 0) d8 = c;
        end
        check("w8 done_cycle", d8, 9);
        check("w8 result", {i8.result_hi, i8.result_lo, i8.flags}, {8'h00, 8'hFF, 4'b1000});
        @(negedge clk);
        i8.start = 1'b0;
        check("w8 b2b busy/done", {i8.busy, i8.done}, 2'b10);
        d8 = 0;
        for (int c = 11; c <= 19; c++) begin
            @(negedge clk);
            if (i8.done && d8 == 0) d8 = c;
        end
        check("w8 b2b done_cycle", d8, 18);
        check("w8 b2b result", {i8.result_hi, i8.result_lo, i8.flags}, {8'h00, 8'd15, 4'b0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/arm_muldiv.md
# arm_muldiv

Parametrised iterative multiply/divide unit for the multicycle ARM core. It sits beside the ALU in the datapath. The controller holds in an execute-wait state while `busy` is high and writes results back when `done` pulses. Operands are processed one bit per cycle, so area stays small, and `WIDTH` scales the unit to narrower or wider datapaths.

## Interface
- `WIDTH`, default 32: operand and result width. Legal values are ≥4 and even.
- `clk` in 1: clock. **One clock; reset is synchronous and active-high.**
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a new operation. Sampled on the rising edge.
- `op` in 3: operation select.
  - `op[1:0]`: 00 MUL (low product), 01 MULL (full product), 10 DIV, 11 reserved (treated as MUL).
  - `op[2]`: signed select (see Configuration).
- `a` in WIDTH: multiplicand or dividend. Sampled only on an accepted start.
- `b` in WIDTH: multiplier or divisor. Sampled only on an accepted start.
- `busy` out 1: an operation is in progress. New starts are ignored while it is high.
- `done` out 1: one-cycle pulse; results are valid from this cycle.
- `result_lo` out WIDTH: product[WIDTH-1:0] for MUL/MULL, quotient for DIV.
- `result_hi` out WIDTH: product[2·WIDTH-1:WIDTH] for MULL, remainder for DIV, 0 for MUL.
- `flags` out 4: {N,Z,C,V}, same ordering as the ALU flags. C is always 0.
- `div_by_zero` out 1: set with `done` when a DIV had b==0.

## Operation
- FSM states:
  - IDLE: waits for start.
  - PREP: sign fix; present only when signed support is compiled in.
  - RUN: iterates; WIDTH cycles, counted by a log2(WIDTH)+1-bit step counter.
  - FIX: sign fix; present only when signed support is compiled in.
  - DONE: one cycle, then returns to IDLE.
- Start acceptance:
  - A start is accepted in IDLE and in DONE; the new operation begins immediately.
  - A start in RUN, PREP or FIX is ignored.
- MUL/MULL: shift-add over a 2·WIDTH accumulator, one multiplier bit per step, LSB first.
- DIV: restoring division, one quotient bit per step, MSB first. The remainder register is WIDTH+1 bits wide.
- Divide by zero:
  - Detected when the start is accepted; RUN is skipped and the unit goes straight to DONE.
  - Results: quotient = all ones, remainder = a, `div_by_zero` = 1.
- Flags:
  - N: MSB of `result_hi` for MULL, MSB of `result_lo` otherwise.
  - Z: set when the selected result is entirely zero. For MULL this is all 2·WIDTH bits; for MUL and DIV it is `result_lo` only.
  - V: 0, except for signed overflow (see Configuration).
- Output hold:
  - `result_lo`, `result_hi`, `flags` and `div_by_zero` update only in the DONE cycle.
  - They hold their values until the next DONE or reset.
- Reset, including in mid-operation:
  - The FSM returns to IDLE and the operation in progress is lost.
  - All outputs go to 0: `busy`=0, `done`=0, `result_lo`=0, `result_hi`=0, `flags`=0, `div_by_zero`=0.

## Timing
- Start accepted at edge k:
  - Unsigned: `busy` is high in cycles k+1 through k+WIDTH; `done` is high in cycle k+WIDTH+1.
  - Signed: `busy` is high in cycles k+1 through k+WIDTH+2; `done` is high in cycle k+WIDTH+3.
  - Divide by zero: `busy` never rises; `done` is high in cycle k+1.
- `busy` and `done` are never high in the same cycle.
- Back-to-back operation: a start held high during DONE is accepted, and `busy` rises on the next cycle.
- Operands may change at any time after the accepting edge.

## Configuration
- Macro: `ARM_MULDIV_SIGNED_EN`.
- Defined:
  - `op[2]`=1 selects signed operands. PREP takes absolute values; FIX negates the results.
  - The quotient truncates toward zero, and the remainder takes the sign of the dividend.
  - MIN / -1 returns quotient = MIN, remainder = 0, V = 1.
  - MULL returns the signed 2·WIDTH-bit product.
- Undefined:
  - `op[2]` is ignored and every operation is unsigned.
  - The PREP and FIX states and the negation logic are not built.

## Test plan
- WIDTH=32, MUL 7×6, start at cycle 0 → `busy` high in cycles 1–32, `done` in cycle 33, `result_lo`=42, `result_hi`=0, `flags`=0000.
- MULL 0xFFFFFFFF×0xFFFFFFFF → `result_hi`=0xFFFFFFFE, `result_lo`=0x00000001, N=1, Z=0.
- DIV 100/7 → `result_lo`=14, `result_hi`=2, `div_by_zero`=0. Then DIV 5/0 → `done` in cycle 1, `result_lo`=0xFFFFFFFF, `result_hi`=5, `div_by_zero`=1.
- Start pulsed in cycle 5 of a running MUL → ignored, and the first result is unaffected. Reset asserted in cycle 10 of a DIV → all outputs 0; the next start completes normally.
- With `ARM_MULDIV_SIGNED_EN`:
  - Signed DIV -7/2 → `result_lo`=0xFFFFFFFD, `result_hi`=0xFFFFFFFF, `done` in cycle 35.
  - Signed DIV 0x80000000/-1 → quotient 0x80000000, V=1.
- WIDTH=8, MUL 15×17 → `done` in cycle 9, `result_lo`=0xFF. A start held high during DONE → the next op is accepted and `busy` rises in the following cycle.
